// File: rtl/cas_key_pkg.sv
// rtl/cas_key_pkg.sv - shared types, default widths and check-segment fold for the key loader
// Optional feature macro: KEY_CHK_EN (seg_xor is only used when it is defined).
package cas_key_pkg;

  localparam int KEY_W_DEF = 64;
  localparam int SEG_W_DEF = 8;
  localparam int KEY_W_MAX = 512;
  localparam int SEG_W_MAX = 64;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} key_ld_state_t;

  // Bit i of the key folds into bit (i mod seg_w); zero-extended upper bits add nothing.
  function automatic logic [SEG_W_MAX-1:0] seg_xor(input logic [KEY_W_MAX-1:0] key,
                                                   input int seg_w);
    logic [SEG_W_MAX-1:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_W_MAX; i++) begin
      acc[i % seg_w] = acc[i % seg_w] ^ key[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/cas_key_loader_if.sv
// rtl/cas_key_loader_if.sv - segment stream carrying key segments into the loader
interface cas_key_loader_if #(
  parameter int SEG_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [SEG_W-1:0] s_data;
  logic             s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/cas_key_shadow.sv
// rtl/cas_key_shadow.sv - segment-addressed shadow register with an atomic parallel commit port
module cas_key_shadow #(
  parameter int KEY_W = 64,
  parameter int SEG_W = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [SEG_W-1:0] wr_data_i,
  input  logic             commit_i,
  input  logic             key_clr_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic [KEY_W-1:0] key_o
);

  localparam int NSEG = KEY_W / SEG_W;

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;

  always_comb begin
    shadow_d = shadow_q;
    if (clr_i) begin
      shadow_d = '0;
    end else if (wr_en_i) begin
      for (int k = 0; k < NSEG; k++) begin
        if (wr_idx_i == IDX_W'(k)) shadow_d[k*SEG_W +: SEG_W] = wr_data_i;
      end
    end
  end

  always_comb begin
    key_d = key_q;
    if (key_clr_i)     key_d = '0;
    else if (commit_i) key_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      key_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      key_q    <= key_d;
    end
  end

  assign shadow_o = shadow_q;
  assign key_o    = key_q;

endmodule

// File: rtl/cas_key_loader.sv
// rtl/cas_key_loader.sv - assembles streamed key segments and commits them to the locked-netlist key bus
// Optional feature macro: KEY_CHK_EN adds a trailing XOR check segment to each frame.
module cas_key_loader
  import cas_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cas_key_loader_if.slave        s_if,
  input  logic                   zeroize_i,
  output logic [KEY_W-1:0]       key_out_o,
  output logic                   key_valid_o,
  output logic                   load_err_o
);

  localparam int NSEG  = KEY_W / SEG_W;
  localparam int CNT_W = $clog2(NSEG + 2);
  localparam logic [CNT_W-1:0] NSEG_C = CNT_W'(NSEG);
`ifdef KEY_CHK_EN
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSEG);
`else
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSEG - 1);
`endif

  if (KEY_W % SEG_W != 0) begin : g_bad_width
    $error("KEY_W must be a multiple of SEG_W");
  end

  key_ld_state_t    state_q, state_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic             key_valid_q, key_valid_d;
  logic             load_err_q, load_err_d;
  logic             rdy_en_q;

  logic             accept;
  logic [CNT_W-1:0] idx;
  logic             chk_ok;
  logic             wr_en, sh_clr, commit, key_clr;
  logic [KEY_W-1:0] shadow;

  // Hold s_ready low while in reset and for the reset-release edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign s_if.s_ready = rdy_en_q && (state_q != COMMIT);
  assign accept       = s_if.s_valid && s_if.s_ready;
  assign idx          = (state_q == IDLE) ? '0 : seg_cnt_q;

`ifdef KEY_CHK_EN
  logic [SEG_W-1:0] chk_exp;
  assign chk_exp = SEG_W'(seg_xor(KEY_W_MAX'(shadow), SEG_W));
  assign chk_ok  = (s_if.s_data == chk_exp);
`else
  assign chk_ok  = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    seg_cnt_d   = seg_cnt_q;
    key_valid_d = key_valid_q;
    load_err_d  = load_err_q;
    wr_en       = 1'b0;
    sh_clr      = 1'b0;
    commit      = 1'b0;
    key_clr     = 1'b0;

    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (state_q == IDLE) load_err_d = 1'b0;
          wr_en = (idx < NSEG_C);
          if (idx == LAST_IDX) begin
            seg_cnt_d = '0;
            if (s_if.s_last && chk_ok) begin
              state_d = COMMIT;
            end else begin
              load_err_d = 1'b1;
              sh_clr     = 1'b1;
              state_d    = s_if.s_last ? IDLE : DRAIN;
            end
          end else if (s_if.s_last) begin
            load_err_d = 1'b1;
            sh_clr     = 1'b1;
            seg_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            seg_cnt_d = idx + CNT_W'(1);
            state_d   = LOAD;
          end
        end
      end
      COMMIT: begin
        commit      = 1'b1;
        key_valid_d = 1'b1;
        state_d     = IDLE;
      end
      DRAIN: begin
        if (accept && s_if.s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Zeroize wins over any same-edge transfer or commit; load_err is left alone.
    if (zeroize_i) begin
      state_d     = IDLE;
      seg_cnt_d   = '0;
      key_valid_d = 1'b0;
      wr_en       = 1'b0;
      commit      = 1'b0;
      sh_clr      = 1'b1;
      key_clr     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seg_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
    end
  end

  cas_key_shadow #(
    .KEY_W (KEY_W),
    .SEG_W (SEG_W),
    .IDX_W (CNT_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (sh_clr),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx),
    .wr_data_i (s_if.s_data),
    .commit_i  (commit),
    .key_clr_i (key_clr),
    .shadow_o  (shadow),
    .key_o     (key_out_o)
  );

  assign key_valid_o = key_valid_q;
  assign load_err_o  = load_err_q;

endmodule
